ntt_addr_seq: RTL and testbench
===============================

// Module: ntt_addr_seq
// PURPOSE
//  Upstream sequencer for the 128-entry NTT address ROM (7-bit addr, 21-bit word = three 7-bit fields).
//  Walks a programmable address range, absorbs the ROM's 1-cycle registered read latency,
//  and presents each word as a valid/ready stream to the butterfly memory-access stage.
//  Downstream back-pressure never drops or duplicates a word.
// PARAMETERS
//  AW          7   ROM address width; range wraps modulo 2**AW
//  FW          7   width of one address field
//  FIFO_DEPTH  4   output buffer entries; must be >= 3 for 1 word/cycle throughput
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  start       in   1      one-cycle request to begin a walk; sampled only in IDLE
//  first_addr  in   AW     first ROM address of the walk, latched on accepted start
//  last_addr   in   AW     last ROM address of the walk (inclusive), latched on accepted start
//  rom_addr    out  AW     address to ROM (registered)
//  rom_wr_ena  out  1      constant 0
//  rom_data    in   3*FW   ROM read word, valid one cycle after the ROM samples rom_addr
//  out_valid   out  1      out_a/b/c hold a valid word
//  out_ready   in   1      consumer accepts the word when out_valid && out_ready
//  out_a       out  FW     rom_data[3*FW-1:2*FW] of head word
//  out_b       out  FW     rom_data[2*FW-1:FW]
//  out_c       out  FW     rom_data[FW-1:0]
//  busy        out  1      high in RUN and DRAIN
//  done        out  1      one-cycle pulse when the last word of a walk is accepted downstream
// BEHAVIOUR
//  Reset: state=IDLE, FIFO and pending flags cleared.
//   rom_addr, out_valid, out_a/b/c, busy and done are all 0.
//  States: IDLE -> RUN on start. RUN -> DRAIN when the last address is issued.
//   DRAIN -> IDLE when the FIFO is empty and no read is pending; done pulses on that transition edge.
//  Accepted start latches cur=first_addr and remaining=((last_addr-first_addr) mod 2**AW)+1.
//   remaining is AW+1 bits wide, range 1..128.
//   first_addr==last_addr means a 1-word walk. last_addr<first_addr wraps through 127 -> 0.
//  start while busy is ignored; latched range and counters are unchanged.
//  Issue (RUN only): allowed when fifo_occ + pending - pop < FIFO_DEPTH.
//   pending = issued addresses whose data is not yet in the FIFO; at most 2.
//   pop = out_valid && out_ready in the same cycle.
//   On issue: rom_addr<=cur; cur<=cur+1 mod 2**AW; remaining<=remaining-1.
//  Read pipeline: 2-stage valid shift (v0 = rom_addr loaded, v1 = rom_data valid).
//   The FIFO writes rom_data on a cycle with v1=1.
//  Latency: the edge that samples start loads rom_addr=first_addr.
//   out_valid rises after the 3rd edge counting that one.
//  Throughput: 1 word/cycle with out_ready held high after fill.
//  Output: FIFO head is registered. out_a/b/c hold stable while out_valid && !out_ready.
//   Fields are passed verbatim with no arithmetic.
//  Simultaneous FIFO write and pop is legal; occupancy is unchanged. The FIFO never overflows.
//  rom_addr holds its last value when no issue occurs.
//  The ROM is free-running, so unissued reads are discarded via v0/v1.
//  rst asserted mid-walk: all state returns to reset values on that edge.
//   No done pulse. In-flight words are dropped.
// TESTING
//  T1 first=0,last=127,ready=1 -> 128 words, in address order.
//   word0={96,32,64}, word32={72,8,16}, word64={66,2,4}, word96={0,97,0}.
//   done once, on the edge of the 128th accept. 1 word/cycle after fill.
//  T2 T1 range with ready low for 20 cycles mid-walk, then random toggling.
//   -> identical 128-word sequence, no loss or duplication.
//   -> fifo_occ never exceeds FIFO_DEPTH; out_* stable while stalled.
//  T3 first=120,last=3 -> 12 words, addresses 120..127,0..3.
//   word0={120,56,112}, last word={3,100,0}.
//  T4 first=last=64 -> exactly one word {66,2,4}, then done, then IDLE (busy=0).
//  T5 rst for 1 cycle while 10 words pending -> next cycle all outputs 0, no done.
//   A new start then gives a correct full walk.
//  T6 start pulsed again while busy with different range -> ignored; the original walk completes unchanged.

Source files
------------

// File: rtl/ntt_addr_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_addr_seq_if
//  Purpose  : Valid/ready word stream from the NTT address sequencer to the
//             butterfly memory-access stage (three address fields per word).
//  Revision : 1.0 - initial release
// ============================================================================
interface ntt_addr_seq_if #(
   parameter int FW = 7
) ();
   logic          valid;
   logic          ready;
   logic [FW-1:0] a;
   logic [FW-1:0] b;
   logic [FW-1:0] c;

   modport master (output valid, output a, output b, output c, input ready);
   modport slave  (input valid, input a, input b, input c, output ready);
endinterface
`default_nettype wire

// File: rtl/ntt_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_addr_seq
//  Purpose  : Walks a programmable ROM address range, absorbs the ROM's
//             one-cycle registered read latency and streams each 3-field word
//             out through a small registered FIFO with full back-pressure.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_addr_seq #(
   parameter int AW         = 7,
   parameter int FW         = 7,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [AW-1:0]     first_addr_i,
   input  logic [AW-1:0]     last_addr_i,
   output logic [AW-1:0]     rom_addr_o,
   output logic              rom_wr_ena_o,
   input  logic [3*FW-1:0]   rom_data_i,
   output logic              busy_o,
   output logic              done_o,
   ntt_addr_seq_if.master    out_if
);

   localparam int DW    = 3 * FW;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [OCC_W:0] C_DEPTH = (OCC_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     cur_q, cur_d;
   logic [AW:0]       rem_q, rem_d;
   logic [AW-1:0]     rom_addr_q, rom_addr_d;
   logic              v0_q, v0_d;
   logic              v1_q, v1_d;
   logic              done_q, done_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [DW-1:0]     mem_q [FIFO_DEPTH];
   logic [DW-1:0]     mem_d [FIFO_DEPTH];

   logic              w_pop;
   logic              w_push;
   logic [OCC_W:0]    w_inflight;
   logic [OCC_W:0]    w_limit;
   logic              w_room;
   logic [AW-1:0]     w_span;
   logic [OCC_W-1:0]  w_wr_idx;
   logic [DW-1:0]     w_ext [FIFO_DEPTH+1];

   // Handshake, credit and range arithmetic shared by the FSM and the FIFO.
   always_comb begin
      w_pop      = (occ_q != '0) && out_if.ready;
      w_push     = v1_q;
      // Words already buffered plus reads still in the ROM pipeline must
      // leave a free slot, counting the slot freed by a pop this cycle.
      w_inflight = {1'b0, occ_q} + {{OCC_W{1'b0}}, v0_q} + {{OCC_W{1'b0}}, v1_q};
      w_limit    = C_DEPTH + {{OCC_W{1'b0}}, w_pop};
      w_room     = (w_inflight < w_limit);
      w_span     = last_addr_i - first_addr_i;
   end

   // Next-state logic for the walk FSM, address generator and read pipeline.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rem_d      = rem_q;
      rom_addr_d = rom_addr_q;
      v0_d       = 1'b0;
      v1_d       = v0_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               // The accepting edge also issues first_addr, so the count of
               // addresses still to issue is (span + 1) - 1 = span.
               rom_addr_d = first_addr_i;
               cur_d      = first_addr_i + AW'(1);
               rem_d      = {1'b0, w_span};
               v0_d       = 1'b1;
               state_d    = (first_addr_i == last_addr_i) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (w_room) begin
               rom_addr_d = cur_q;
               cur_d      = cur_q + AW'(1);
               rem_d      = rem_q - (AW + 1)'(1);
               v0_d       = 1'b1;
               if (rem_q == (AW + 1)'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // The final word leaves on this edge when nothing else is
            // buffered or still in flight from the ROM.
            if (!v0_q && !v1_q && (occ_q == OCC_W'(1)) && w_pop) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Shift-register FIFO: entry 0 is the registered head, pops shift down,
   // the ROM word lands in the first free slot after any shift.
   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         w_ext[i] = mem_q[i];
      end
      w_ext[FIFO_DEPTH] = '0;
      w_wr_idx = w_pop ? (occ_q - OCC_W'(1)) : occ_q;
      occ_d    = occ_q + OCC_W'(w_push) - OCC_W'(w_pop);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         mem_d[i] = w_pop ? w_ext[i+1] : w_ext[i];
         if (w_push && (w_wr_idx == OCC_W'(i))) begin
            mem_d[i] = rom_data_i;
         end
      end
   end

   // State register for FSM, counters, read pipeline and FIFO storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cur_q      <= '0;
         rem_q      <= '0;
         rom_addr_q <= '0;
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         done_q     <= 1'b0;
         occ_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rem_q      <= rem_d;
         rom_addr_q <= rom_addr_d;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         done_q     <= done_d;
         occ_q      <= occ_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Output mapping straight from registers.
   always_comb begin
      rom_addr_o   = rom_addr_q;
      rom_wr_ena_o = 1'b0;
      busy_o       = (state_q != S_IDLE);
      done_o       = done_q;
      out_if.valid = (occ_q != '0);
      out_if.a     = mem_q[0][3*FW-1:2*FW];
      out_if.b     = mem_q[0][2*FW-1:FW];
      out_if.c     = mem_q[0][FW-1:0];
   end

endmodule
`default_nettype wire

// File: tb/tb_ntt_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_addr_seq
//  Purpose  : Directed self-checking bench for ntt_addr_seq with a
//             registered-read ROM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_addr_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [6:0]  first_addr;
   logic [6:0]  last_addr;
   logic [6:0]  rom_addr;
   logic        rom_wr_ena;
   logic [20:0] rom_data;
   logic        busy;
   logic        done;

   int n_tests;
   int n_fail;

   ntt_addr_seq_if #(.FW(7)) out_if ();

   ntt_addr_seq #(.AW(7), .FW(7), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .first_addr_i (first_addr),
      .last_addr_i  (last_addr),
      .rom_addr_o   (rom_addr),
      .rom_wr_ena_o (rom_wr_ena),
      .rom_data_i   (rom_data),
      .busy_o       (busy),
      .done_o       (done),
      .out_if       (out_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: known table entries, otherwise a distinct per-address word.
   function automatic logic [20:0] rom_word(input logic [6:0] ad);
      case (ad)
         7'd0:    rom_word = {7'd96, 7'd32, 7'd64};
         7'd3:    rom_word = {7'd3, 7'd100, 7'd0};
         7'd32:   rom_word = {7'd72, 7'd8, 7'd16};
         7'd64:   rom_word = {7'd66, 7'd2, 7'd4};
         7'd96:   rom_word = {7'd0, 7'd97, 7'd0};
         7'd120:  rom_word = {7'd120, 7'd56, 7'd112};
         default: rom_word = {ad, ad ^ 7'h55, ~ad};
      endcase
   endfunction

   // Free-running ROM with a one-cycle registered read.
   always_ff @(posedge clk) rom_data <= rom_word(rom_addr);

   logic [20:0] got[$];
   int first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cnt, done_cyc;
   int stall_viol, occ_max;
   bit timed_out;

   task automatic do_start(input logic [6:0] f, input logic [6:0] l);
      @(negedge clk);
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
   endtask

   // Records accepted words and done pulses until shortly after done.
   task automatic collect(input int max_cyc, input int mode, input int restart_cyc);
      logic [20:0] cur_word;
      logic [20:0] prev_word;
      logic        prev_stall;
      bit          seen_done;
      int          tail;
      got.delete();
      first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
      done_cnt = 0; done_cyc = -1; stall_viol = 0; occ_max = 0;
      timed_out = 1'b1; prev_stall = 1'b0; prev_word = '0;
      seen_done = 1'b0; tail = 0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clk);
         start = (cyc == restart_cyc);
         if (cyc == restart_cyc) begin
            first_addr = 7'd5;
            last_addr  = 7'd9;
         end
         if (mode == 0 || cyc < 10) out_if.ready = 1'b1;
         else if (cyc < 30)         out_if.ready = 1'b0;
         else                       out_if.ready = 1'($urandom_range(0, 1));
         cur_word = {out_if.a, out_if.b, out_if.c};
         if (int'(dut.occ_q) > occ_max) occ_max = int'(dut.occ_q);
         if (prev_stall && (!out_if.valid || cur_word != prev_word)) stall_viol++;
         if (out_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            seen_done = 1'b1;
         end
         if (out_if.valid && out_if.ready) begin
            got.push_back(cur_word);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
         end
         prev_stall = out_if.valid && !out_if.ready;
         prev_word  = cur_word;
         if (seen_done) begin
            tail++;
            if (tail > 4) begin
               timed_out = 1'b0;
               break;
            end
         end
      end
      out_if.ready = 1'b1;
      start        = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({rom_addr, out_if.valid} !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_addr_valid: got addr=%0d valid=%0b expected 0 0", rom_addr, out_if.valid);
      end
      n_tests++;
      if ({out_if.a, out_if.b, out_if.c} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_fields: got %h expected 0", {out_if.a, out_if.b, out_if.c});
      end
      n_tests++;
      if ({busy, done, rom_wr_ena} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_busy_done_wr: got %b expected 000", {busy, done, rom_wr_ena});
      end
      rst = 1'b0;
   endtask

   task automatic test_full_walk();
      int bad;
      do_start(7'd0, 7'd127);
      collect(400, 0, 0);
      n_tests++;
      if (timed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_timeout: got timed_out=%0b expected 0", timed_out);
      end
      n_tests++;
      if (got.size() !== 128) begin
         n_fail++;
         $display("FAIL t1_count: got %0d expected 128", got.size());
      end
      bad = 0;
      foreach (got[k]) if (got[k] !== rom_word(7'(k))) bad++;
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL t1_order: got %0d wrong words expected 0", bad);
      end
      if (got.size() == 128) begin
         n_tests++;
         if (got[0] !== {7'd96, 7'd32, 7'd64}) begin
            n_fail++;
            $display("FAIL t1_word0: got %h expected %h", got[0], {7'd96, 7'd32, 7'd64});
         end
         n_tests++;
         if (got[32] !== {7'd72, 7'd8, 7'd16}) begin
            n_fail++;
            $display("FAIL t1_word32: got %h expected %h", got[32], {7'd72, 7'd8, 7'd16});
         end
         n_tests++;
         if (got[64] !== {7'd66, 7'd2, 7'd4}) begin
            n_fail++;
            $display("FAIL t1_word64: got %h expected %h", got[64], {7'd66, 7'd2, 7'd4});
         end
         n_tests++;
         if (got[96] !== {7'd0, 7'd97, 7'd0}) begin
            n_fail++;
            $display("FAIL t1_word96: got %h expected %h", got[96], {7'd0, 7'd97, 7'd0});
         end
      end
      n_tests++;
      if (first_valid_cyc !== 3) begin
         n_fail++;
         $display("FAIL t1_latency: got valid at cycle %0d expected 3", first_valid_cyc);
      end
      n_tests++;
      if (last_acc_cyc - first_acc_cyc !== 127) begin
         n_fail++;
         $display("FAIL t1_throughput: got span %0d expected 127", last_acc_cyc - first_acc_cyc);
      end
      n_tests++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL t1_done_count: got %0d expected 1", done_cnt);
      end
      n_tests++;
      if (done_cyc !== last_acc_cyc + 1) begin
         n_fail++;
         $display("FAIL t1_done_timing: got cycle %0d expected %0d", done_cyc, last_acc_cyc + 1);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_busy_end: got %0b expected 0", busy);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      do_start(7'd0, 7'd127);
      collect(3000, 1, 0);
      n_tests++;
      if (got.size() !== 128 || timed_out !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_count: got %0d words timed_out=%0b expected 128 0", got.size(), timed_out);
      end
      bad = 0;
      foreach (got[k]) if (got[k] !== rom_word(7'(k))) bad++;
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL t2_order: got %0d wrong words expected 0", bad);
      end
      n_tests++;
      if (stall_viol !== 0) begin
         n_fail++;
         $display("FAIL t2_stall_stable: got %0d changes expected 0", stall_viol);
      end
      n_tests++;
      if (occ_max > 4) begin
         n_fail++;
         $display("FAIL t2_occupancy: got max %0d expected <= 4", occ_max);
      end
      n_tests++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL t2_done_count: got %0d expected 1", done_cnt);
      end
   endtask

   task automatic test_wrap();
      int bad;
      do_start(7'd120, 7'd3);
      collect(200, 0, 0);
      n_tests++;
      if (got.size() !== 12) begin
         n_fail++;
         $display("FAIL t3_count: got %0d expected 12", got.size());
      end
      bad = 0;
      foreach (got[k]) if (got[k] !== rom_word(7'(120 + k))) bad++;
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL t3_order: got %0d wrong words expected 0", bad);
      end
      if (got.size() == 12) begin
         n_tests++;
         if (got[0] !== {7'd120, 7'd56, 7'd112}) begin
            n_fail++;
            $display("FAIL t3_first_word: got %h expected %h", got[0], {7'd120, 7'd56, 7'd112});
         end
         n_tests++;
         if (got[11] !== {7'd3, 7'd100, 7'd0}) begin
            n_fail++;
            $display("FAIL t3_last_word: got %h expected %h", got[11], {7'd3, 7'd100, 7'd0});
         end
      end
   endtask

   task automatic test_single();
      do_start(7'd64, 7'd64);
      collect(100, 0, 0);
      n_tests++;
      if (got.size() !== 1) begin
         n_fail++;
         $display("FAIL t4_count: got %0d expected 1", got.size());
      end
      if (got.size() == 1) begin
         n_tests++;
         if (got[0] !== {7'd66, 7'd2, 7'd4}) begin
            n_fail++;
            $display("FAIL t4_word: got %h expected %h", got[0], {7'd66, 7'd2, 7'd4});
         end
      end
      n_tests++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL t4_done_idle: got done_cnt=%0d busy=%0b expected 1 0", done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid_walk();
      int viol;
      int bad;
      out_if.ready = 1'b0;
      do_start(7'd0, 7'd9);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || out_if.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_pre_reset: got busy=%0b valid=%0b expected 1 1", busy, out_if.valid);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({rom_addr, out_if.valid, out_if.a, out_if.b, out_if.c, busy, done} !== 31'd0) begin
         n_fail++;
         $display("FAIL t5_after_reset: got addr=%0d valid=%0b fields=%h busy=%0b done=%0b expected all 0",
                  rom_addr, out_if.valid, {out_if.a, out_if.b, out_if.c}, busy, done);
      end
      out_if.ready = 1'b1;
      viol = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || out_if.valid || busy) viol++;
      end
      n_tests++;
      if (viol !== 0) begin
         n_fail++;
         $display("FAIL t5_quiet: got %0d cycles with done/valid/busy expected 0", viol);
      end
      do_start(7'd0, 7'd127);
      collect(400, 0, 0);
      bad = 0;
      foreach (got[k]) if (got[k] !== rom_word(7'(k))) bad++;
      n_tests++;
      if (got.size() !== 128 || bad !== 0 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL t5_rewalk: got %0d words %0d wrong done=%0d expected 128 0 1", got.size(), bad, done_cnt);
      end
   endtask

   task automatic test_restart_ignored();
      int bad;
      do_start(7'd0, 7'd127);
      collect(400, 0, 20);
      n_tests++;
      if (got.size() !== 128) begin
         n_fail++;
         $display("FAIL t6_count: got %0d expected 128", got.size());
      end
      bad = 0;
      foreach (got[k]) if (got[k] !== rom_word(7'(k))) bad++;
      n_tests++;
      if (bad !== 0 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL t6_order_done: got %0d wrong words done=%0d expected 0 1", bad, done_cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000 expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      start        = 1'b0;
      first_addr   = '0;
      last_addr    = '0;
      out_if.ready = 1'b1;
      test_reset();
      test_full_walk();
      test_backpressure();
      test_wrap();
      test_single();
      test_reset_mid_walk();
      test_restart_ignored();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
